// File: rtl/rf_wb_scheduler_pkg.sv
// Shared types and constants for the register-file write-back scheduler.
// Widths default to the core's register address/data buses.
package rf_wb_scheduler_pkg;

   localparam int RF_ADDR_W   = 5;
   localparam int RF_DATA_W   = 32;
   localparam int RF_NUM_REGS = 32;

   typedef enum logic {
      WB_SRC_ALU = 1'b0,
      WB_SRC_LSU = 1'b1
   } wb_src_e;

   typedef struct packed {
      logic                 valid;
      logic [RF_ADDR_W-1:0] addr;
      logic [RF_DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/rf_wb_scheduler_scoreboard.sv
// Pending-destination scoreboard: one bit per architectural register,
// set by issue, cleared by write-back, with issue winning a same-edge tie.
module rf_scoreboard
   import rf_wb_scheduler_pkg::*;
#(
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NUM_REGS = RF_NUM_REGS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              set_i,
   input  logic [ADDR_W-1:0] set_addr_i,
   input  logic              clr_i,
   input  logic [ADDR_W-1:0] clr_addr_i,
   input  logic [ADDR_W-1:0] chk_addr1_i,
   input  logic [ADDR_W-1:0] chk_addr2_i,
   output logic              hazard_raw_o,
   output logic              hazard_waw_o
);

   logic [NUM_REGS-1:0] pending_q, pending_d;

   // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      pending_d = pending_q;
      if (clr_i) pending_d[clr_addr_i] = 1'b0;
      // A new producer issued on the same edge as the old one retires keeps the bit set.
      if (set_i) pending_d[set_addr_i] = 1'b1;
   end

   // NOTE: this bit vector is ordinary flops, not a RAM, so it is cleared by reset like any other state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pending_q <= '0;
      else     pending_q <= pending_d;
   end

   // Lookups use the registered bits only; a clear on this edge is visible next cycle.
   assign hazard_raw_o = pending_q[chk_addr1_i] | pending_q[chk_addr2_i];
   assign hazard_waw_o = set_i & pending_q[set_addr_i];

endmodule

// File: rtl/rf_wb_scheduler.sv
// Round-robin arbiter of ALU and LSU write-backs onto the single register-file
// write port, with a registered write stage and the pending-destination scoreboard.
module rf_wb_scheduler
   import rf_wb_scheduler_pkg::*;
#(
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int DATA_W   = RF_DATA_W,
   parameter int NUM_REGS = RF_NUM_REGS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb0_valid,
   input  logic [ADDR_W-1:0] wb0_addr,
   input  logic [DATA_W-1:0] wb0_data,
   output logic              wb0_ready,
   input  logic              wb1_valid,
   input  logic [ADDR_W-1:0] wb1_addr,
   input  logic [DATA_W-1:0] wb1_data,
   output logic              wb1_ready,
   output logic              rf_write,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_din,
   input  logic              sb_set,
   input  logic [ADDR_W-1:0] sb_addr,
   input  logic [ADDR_W-1:0] chk_addr1,
   input  logic [ADDR_W-1:0] chk_addr2,
   output logic              hazard_raw,
   output logic              hazard_waw
);

   wb_req_t           req0, req1;
   wb_src_e           last_gnt_q, last_gnt_d;
   logic              gnt0, gnt1, xfer;
   logic [ADDR_W-1:0] gnt_addr;
   logic [DATA_W-1:0] gnt_data;

   logic              rf_write_q;
   logic [ADDR_W-1:0] rf_waddr_q;
   logic [DATA_W-1:0] rf_din_q;

   assign req0 = '{valid: wb0_valid, addr: wb0_addr, data: wb0_data};
   assign req1 = '{valid: wb1_valid, addr: wb1_addr, data: wb1_data};

   // On conflict the requester that did not win the last transfer is granted.
   always_comb begin
      gnt0       = req0.valid & (~req1.valid | (last_gnt_q == WB_SRC_LSU));
      gnt1       = req1.valid & (~req0.valid | (last_gnt_q == WB_SRC_ALU));
      xfer       = gnt0 | gnt1;
      gnt_addr   = gnt1 ? req1.addr : req0.addr;
      gnt_data   = gnt1 ? req1.data : req0.data;
      last_gnt_d = last_gnt_q;
      if (gnt0)      last_gnt_d = WB_SRC_ALU;
      else if (gnt1) last_gnt_d = WB_SRC_LSU;
   end

   assign wb0_ready = gnt0;
   assign wb1_ready = gnt1;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_gnt_q <= WB_SRC_LSU;
         rf_write_q <= 1'b0;
         rf_waddr_q <= '0;
         rf_din_q   <= '0;
      end else begin
         last_gnt_q <= last_gnt_d;
         rf_write_q <= xfer;
         if (xfer) begin
            rf_waddr_q <= gnt_addr;
            rf_din_q   <= gnt_data;
         end
      end
   end

   assign rf_write = rf_write_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_din   = rf_din_q;

   rf_scoreboard #(
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_scoreboard (
      .clk          (clk),
      .rst          (rst),
      .set_i        (sb_set),
      .set_addr_i   (sb_addr),
      .clr_i        (xfer),
      .clr_addr_i   (gnt_addr),
      .chk_addr1_i  (chk_addr1),
      .chk_addr2_i  (chk_addr2),
      .hazard_raw_o (hazard_raw),
      .hazard_waw_o (hazard_waw)
   );

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed, table-driven bench for rf_wb_scheduler with hand-computed expectations,
// plus a hand-written mid-operation reset sequence.
module tb_rf_wb_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb0_valid, wb1_valid, sb_set;
   logic [4:0]  wb0_addr, wb1_addr, sb_addr, chk_addr1, chk_addr2;
   logic [31:0] wb0_data, wb1_data;
   logic        wb0_ready, wb1_ready, rf_write, hazard_raw, hazard_waw;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_din;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rf_wb_scheduler dut (
      .clk        (clk),
      .rst        (rst),
      .wb0_valid  (wb0_valid),
      .wb0_addr   (wb0_addr),
      .wb0_data   (wb0_data),
      .wb0_ready  (wb0_ready),
      .wb1_valid  (wb1_valid),
      .wb1_addr   (wb1_addr),
      .wb1_data   (wb1_data),
      .wb1_ready  (wb1_ready),
      .rf_write   (rf_write),
      .rf_waddr   (rf_waddr),
      .rf_din     (rf_din),
      .sb_set     (sb_set),
      .sb_addr    (sb_addr),
      .chk_addr1  (chk_addr1),
      .chk_addr2  (chk_addr2),
      .hazard_raw (hazard_raw),
      .hazard_waw (hazard_waw)
   );

   typedef struct {
      logic        v0;  logic [4:0] a0; logic [31:0] d0;
      logic        v1;  logic [4:0] a1; logic [31:0] d1;
      logic        set; logic [4:0] sa; logic [4:0]  c1; logic [4:0] c2;
      logic        r0;  logic r1;   logic wr;
      logic [4:0]  wa;  logic [31:0] wd;
      logic        raw; logic waw;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(
      logic v0, logic [4:0] a0, logic [31:0] d0,
      logic v1, logic [4:0] a1, logic [31:0] d1,
      logic set, logic [4:0] sa, logic [4:0] c1, logic [4:0] c2,
      logic r0, logic r1, logic wr, logic [4:0] wa, logic [31:0] wd,
      logic raw, logic waw);
      vec_t v;
      v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
      v.set = set; v.sa = sa; v.c1 = c1; v.c2 = c2;
      v.r0 = r0; v.r1 = r1; v.wr = wr; v.wa = wa; v.wd = wd;
      v.raw = raw; v.waw = waw;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      wb0_valid = 0; wb0_addr = 0; wb0_data = 0;
      wb1_valid = 0; wb1_addr = 0; wb1_data = 0;
      sb_set = 0; sb_addr = 0; chk_addr1 = 0; chk_addr2 = 0;
   endtask

   initial begin
      // Each row: inputs applied after a falling edge, outputs sampled 1 ns later,
      // registered outputs reflecting the rising edges before that row.
      //            v0 a0  d0       v1 a1  d1       set sa c1  c2   r0 r1 wr wa  wd       raw waw
      vq.push_back(mk(0, 0,  0,       0, 0,  0,       0, 0,  0,  0,   0, 0, 0, 0,  0,       0, 0));
      vq.push_back(mk(1, 4,  'hA,     1, 5,  'hB,     0, 0,  0,  0,   1, 0, 0, 0,  0,       0, 0));
      vq.push_back(mk(0, 0,  0,       1, 5,  'hB,     0, 0,  0,  0,   0, 1, 1, 4,  'hA,     0, 0));
      vq.push_back(mk(0, 0,  0,       0, 0,  0,       0, 0,  0,  0,   0, 0, 1, 5,  'hB,     0, 0));
      vq.push_back(mk(0, 0,  0,       0, 0,  0,       0, 0,  0,  0,   0, 0, 0, 5,  'hB,     0, 0));
      vq.push_back(mk(1, 3,  'h11,    0, 0,  0,       0, 0,  0,  0,   1, 0, 0, 5,  'hB,     0, 0));
      vq.push_back(mk(0, 0,  0,       0, 0,  0,       0, 0,  0,  0,   0, 0, 1, 3,  'h11,    0, 0));
      vq.push_back(mk(0, 0,  0,       1, 6,  'h66,    0, 0,  0,  0,   0, 1, 0, 3,  'h11,    0, 0));
      // Six cycles of continuous contention: grants alternate ALU, LSU, ...
      vq.push_back(mk(1, 1,  'h101,   1, 2,  'h201,   0, 0,  0,  0,   1, 0, 1, 6,  'h66,    0, 0));
      vq.push_back(mk(1, 8,  'h102,   1, 2,  'h201,   0, 0,  0,  0,   0, 1, 1, 1,  'h101,   0, 0));
      vq.push_back(mk(1, 8,  'h102,   1, 10, 'h202,   0, 0,  0,  0,   1, 0, 1, 2,  'h201,   0, 0));
      vq.push_back(mk(1, 12, 'h103,   1, 10, 'h202,   0, 0,  0,  0,   0, 1, 1, 8,  'h102,   0, 0));
      vq.push_back(mk(1, 12, 'h103,   1, 14, 'h203,   0, 0,  0,  0,   1, 0, 1, 10, 'h202,   0, 0));
      vq.push_back(mk(1, 16, 'h104,   1, 14, 'h203,   0, 0,  0,  0,   0, 1, 1, 12, 'h103,   0, 0));
      vq.push_back(mk(0, 0,  0,       0, 0,  0,       0, 0,  0,  0,   0, 0, 1, 14, 'h203,   0, 0));
      vq.push_back(mk(0, 0,  0,       0, 0,  0,       0, 0,  0,  0,   0, 0, 0, 14, 'h203,   0, 0));
      // Scoreboard: set, RAW lookup, clear by LSU write-back.
      vq.push_back(mk(0, 0,  0,       0, 0,  0,       1, 7,  7,  0,   0, 0, 0, 14, 'h203,   0, 0));
      vq.push_back(mk(0, 0,  0,       1, 7,  'h77,    0, 0,  7,  0,   0, 1, 0, 14, 'h203,   1, 0));
      vq.push_back(mk(0, 0,  0,       0, 0,  0,       0, 0,  7,  0,   0, 0, 1, 7,  'h77,    0, 0));
      // Same-address set and clear on one edge: set wins.
      vq.push_back(mk(0, 0,  0,       0, 0,  0,       1, 9,  0,  9,   0, 0, 0, 7,  'h77,    0, 0));
      vq.push_back(mk(1, 9,  'h99,    0, 0,  0,       1, 9,  0,  9,   1, 0, 0, 7,  'h77,    1, 1));
      vq.push_back(mk(0, 0,  0,       0, 0,  0,       1, 9,  0,  9,   0, 0, 1, 9,  'h99,    1, 1));
      // Different-address set and clear on one edge: both take effect.
      vq.push_back(mk(0, 0,  0,       1, 9,  'h90,    1, 11, 9,  11,  0, 1, 0, 9,  'h99,    1, 0));
      vq.push_back(mk(0, 0,  0,       0, 0,  0,       0, 0,  9,  0,   0, 0, 1, 9,  'h90,    0, 0));
      vq.push_back(mk(0, 0,  0,       0, 0,  0,       0, 0,  11, 0,   0, 0, 0, 9,  'h90,    1, 0));

      drive_idle();
      rst = 1'b1;
      #2;
      check("reset rf_write", {31'd0, rf_write}, 0);
      check("reset rf_waddr", {27'd0, rf_waddr}, 0);
      check("reset rf_din", rf_din, 0);
      check("reset hazard_raw", {31'd0, hazard_raw}, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      foreach (vq[i]) begin
         @(negedge clk);
         wb0_valid = vq[i].v0; wb0_addr = vq[i].a0; wb0_data = vq[i].d0;
         wb1_valid = vq[i].v1; wb1_addr = vq[i].a1; wb1_data = vq[i].d1;
         sb_set = vq[i].set; sb_addr = vq[i].sa;
         chk_addr1 = vq[i].c1; chk_addr2 = vq[i].c2;
         #1;
         check($sformatf("v%0d wb0_ready", i), {31'd0, wb0_ready}, {31'd0, vq[i].r0});
         check($sformatf("v%0d wb1_ready", i), {31'd0, wb1_ready}, {31'd0, vq[i].r1});
         check($sformatf("v%0d rf_write", i), {31'd0, rf_write}, {31'd0, vq[i].wr});
         check($sformatf("v%0d rf_waddr", i), {27'd0, rf_waddr}, {27'd0, vq[i].wa});
         check($sformatf("v%0d rf_din", i), rf_din, vq[i].wd);
         check($sformatf("v%0d hazard_raw", i), {31'd0, hazard_raw}, {31'd0, vq[i].raw});
         check($sformatf("v%0d hazard_waw", i), {31'd0, hazard_waw}, {31'd0, vq[i].waw});
      end

      // Reset while a write is in flight, and while a request is being granted.
      @(negedge clk);
      drive_idle();
      sb_set = 1; sb_addr = 20;
      @(negedge clk);
      sb_set = 0; wb0_valid = 1; wb0_addr = 21; wb0_data = 'h55; chk_addr1 = 20;
      #1;
      check("rst-seq pending20 raw", {31'd0, hazard_raw}, 1);
      check("rst-seq wb0_ready", {31'd0, wb0_ready}, 1);
      @(posedge clk);
      #1;
      wb0_valid = 0;
      check("rst-seq write pulse", {31'd0, rf_write}, 1);
      check("rst-seq write addr", {27'd0, rf_waddr}, 21);
      #1 rst = 1'b1;
      #1;
      check("rst-seq rf_write dropped", {31'd0, rf_write}, 0);
      check("rst-seq rf_waddr cleared", {27'd0, rf_waddr}, 0);
      check("rst-seq rf_din cleared", rf_din, 0);
      wb0_valid = 1; wb0_addr = 22; wb0_data = 'h66;
      @(posedge clk);
      #1;
      check("rst-seq no write in reset", {31'd0, rf_write}, 0);
      wb0_valid = 0;
      for (int a = 0; a < 32; a++) begin
         chk_addr1 = a[4:0]; chk_addr2 = 0;
         #1;
         check($sformatf("rst-seq raw r%0d", a), {31'd0, hazard_raw}, 0);
      end
      @(negedge clk);
      rst = 1'b0;
      wb0_valid = 1; wb0_addr = 1; wb0_data = 1;
      wb1_valid = 1; wb1_addr = 2; wb1_data = 2;
      #1;
      check("post-rst first conflict wb0_ready", {31'd0, wb0_ready}, 1);
      check("post-rst first conflict wb1_ready", {31'd0, wb1_ready}, 0);
      drive_idle();
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Write-back scheduler and scoreboard for the pipeline's single-write-port register file.
- Arbitrates two write-back requesters onto the one write port:
  - requester 0: ALU result.
  - requester 1: load/store unit result.
- Tracks the destination registers of in-flight instructions so the issue stage can stall on RAW/WAW hazards.
- Sits between the execute/memory stages and the register file write port.

Parameters:
- ADDR_W, 5, register address width (matches `RegAddrBus).
- DATA_W, 32, register data width (matches `RegBus).
- NUM_REGS, 32, number of architectural registers tracked by the scoreboard.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wb0_valid  in  1  ALU write-back request.
- wb0_addr  in  ADDR_W  ALU destination register.
- wb0_data  in  DATA_W  ALU result.
- wb0_ready  out  1  ALU request granted this cycle.
- wb1_valid  in  1  LSU write-back request.
- wb1_addr  in  ADDR_W  LSU destination register.
- wb1_data  in  DATA_W  LSU load data.
- wb1_ready  out  1  LSU request granted this cycle.
- rf_write  out  1  register file write strobe.
- rf_waddr  out  ADDR_W  register file write address.
- rf_din  out  DATA_W  register file write data.
- sb_set  in  1  issue stage marks a destination as pending.
- sb_addr  in  ADDR_W  destination register being issued.
- chk_addr1  in  ADDR_W  issue-stage source operand 1.
- chk_addr2  in  ADDR_W  issue-stage source operand 2.
- hazard_raw  out  1  a source operand is pending.
- hazard_waw  out  1  sb_addr is already pending.

Behaviour:
- Reset (async, rst=1):
  - pending[] all 0.
  - last_gnt=1, so the ALU wins the first conflict.
  - rf_write=0, rf_waddr=0, rf_din=`ZeroWord.
- Arbitration (combinational):
  - Only wb0 valid: wb0_ready=1.
  - Only wb1 valid: wb1_ready=1.
  - Both valid: grant the requester not recorded in last_gnt (round-robin).
  - At most one ready is high per cycle. Ready never asserts without the matching valid.
  - A transfer occurs when valid && ready at a rising edge.
  - last_gnt updates only on a transfer.
- Handshake rule: requesters hold valid, addr and data stable until ready. The block does not buffer requests.
- Write port (registered, 1-cycle latency):
  - A transfer at edge N drives rf_write=1 with the granted addr/data during cycle N+1.
  - rf_write is a 1-cycle pulse per transfer.
  - With no transfer, rf_write=0 and rf_waddr/rf_din hold their last values.
  - Back-to-back transfers give a continuous rf_write=1 with new addr/data every cycle.
- Scoreboard (NUM_REGS bits):
  - sb_set at an edge sets pending[sb_addr].
  - A write-back transfer at an edge clears pending[granted addr], in the same edge as the grant, not one cycle later.
  - sb_set and clear to the same address in the same edge: set wins (new producer issued).
  - sb_set and clear to different addresses: both take effect.
  - Register 0 gets no special treatment.
- Hazards (combinational from the pending register only; no bypass of same-cycle clears):
  - hazard_raw = pending[chk_addr1] | pending[chk_addr2].
  - hazard_waw = sb_set & pending[sb_addr].
  - The issue stage must not assert sb_set while hazard_waw=1. If it does, the bit stays set and no error is flagged.
- Reset mid-operation:
  - All pending bits clear and any rf_write pulse is dropped immediately.
  - The write scheduled for the next cycle is lost.

Decomposition:
- Shared package or port_define.sv additions:
  - wb_req_t struct {valid, addr, data}.
  - WB_SRC_ALU=0, WB_SRC_LSU=1.
  - Reuse `RegAddrBus, `RegBus, `ZeroWord, `RstEnable, `RegNum.
- One sub-module: rf_scoreboard, containing the pending bit vector, set/clear priority logic and hazard lookups.
- Arbiter and write-port register stay in the top module.

Test Plan:
- Reset release: all outputs 0. Then wb0_valid=1, addr=3, data=0x11 → wb0_ready=1; next cycle rf_write=1, rf_waddr=3, rf_din=0x11; cycle after, rf_write=0.
- Both valid from reset (wb0 addr=4 data=0xA, wb1 addr=5 data=0xB), held until granted → grants ALU, LSU, in that order. rf_write stays high for 2 cycles: (4,0xA) then (5,0xB).
- Both valid continuously for 6 cycles with fresh data → strict alternation of grants 0,1,0,1,0,1; rf_write=1 for 6 consecutive cycles.
- sb_set addr=7, then chk_addr1=7 → hazard_raw=1. wb1 transfer addr=7 → hazard_raw=0 in the cycle after the grant edge.
- Same edge: sb_set addr=9 and wb0 transfer addr=9 with pending[9]=1 → pending[9] stays 1. sb_set addr=9 again → hazard_waw=1.
- Assert rst while a transfer is granted → rf_write=0 immediately, no write occurs, hazard_raw=0 for every address.
